stopwatch_seg_mux: RTL and testbench
====================================

# stopwatch_seg_mux

Time-multiplexed 4-digit seven-segment driver for the stopwatch. It sits directly downstream of the minute/second digit counters. Each clock it takes four 4-bit digit codes plus per-digit decimal-point requests and scans them onto the board's common-anode display. Added beyond a plain hex mux:
- one-cycle anti-ghosting dead time per digit slot,
- leading-zero blanking,
- a blink mode that flashes the display while the stopwatch is paused.

## Interface
Parameters:
- REFRESH_BITS, 18, width of refresh counter; top 2 bits select digit slot (2^(REFRESH_BITS-2) cycles per slot); legal ≥ 3
- BLINK_BITS, 26, width of free-running blink counter; its MSB is the blink phase; legal ≥ 2

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- hex3  in  4  leftmost digit code (minutes tens)
- hex2  in  4  minutes units
- hex1  in  4  seconds tens
- hex0  in  4  rightmost digit code (seconds units)
- dp_in  in  4  decimal-point request, bit i for digit i, 1 = lit
- blank_lz  in  1  1 = blank leading zeros
- blink  in  1  1 = flash display at blink rate
- an  out  4  anode enables, active-low, an[i] drives digit i
- sseg  out  8  segments, active-low; sseg[7]=dp, sseg[6]=a, sseg[5]=b, sseg[4]=c, sseg[3]=d, sseg[2]=e, sseg[1]=f, sseg[0]=g

## Operation
- rcnt (REFRESH_BITS) increments by 1 every clock and wraps to 0. slot = rcnt[MSB:MSB-1]. Slot 0..3 selects digit 0..3.
- bcnt (BLINK_BITS) increments every clock and wraps. It is not gated by blink.
- an and sseg are registered. At each edge they load from a combinational function of the current rcnt, bcnt and inputs.
- Digit d = slot. Default drive: an = one-cold at bit d; sseg[6:0] = enc(hex_d); sseg[7] = ~dp_in[d].
- enc, active-low abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Blank condition. Any true → an=4'b1111, sseg=8'hFF:
  - Dead time: rcnt[MSB-2:0] == 0, i.e. the first cycle of every slot.
  - Leading zero (only when blank_lz=1):
    - digit 3 blank if hex3==0
    - digit 2 blank if hex3==0 && hex2==0
    - digit 1 blank if hex3..hex1 all 0
    - digit 0 never LZ-blanked
  - A blanked digit also suppresses its dp.
  - Blink: blink==1 && bcnt[MSB]==1.
- Inputs are sampled live each cycle, with no internal holding. A change is visible at the next edge if the current slot shows that digit.

## Timing
- Reset (async, immediate, regardless of clk): rcnt=0, bcnt=0, an=4'b1111, sseg=8'hFF.
- First edge after reset release loads from rcnt=0, which is dead time → outputs stay all-off. Digit 0 is driven from the 2nd edge.
- Per slot of S = 2^(REFRESH_BITS-2) cycles: 1 cycle dark, then S-1 cycles driven. The output lags rcnt by one cycle.
- Frame = 4·S cycles. Slot order is 0,1,2,3, then repeats.
- Input-to-output latency: 1 clock.
- Blink period = 2^BLINK_BITS cycles: half dark, half normal. Asserting or deasserting blink takes effect at the next edge.
- Reset asserted mid-frame: outputs go to all-off immediately. The scan restarts at slot 0 on release.
- At most one an bit is low in any cycle. Adjacent slots never overlap.

## Test plan
Use REFRESH_BITS=4 (S=4, frame 16) and BLINK_BITS=6 unless noted.
- Reset: assert reset between edges mid-slot → an=1111, sseg=FF before the next edge. Release → edge 1 all-off; edges 2-4 an=1110.
- Scan: hex3..0=1,2,3,4, dp_in=0, blank_lz=0, blink=0 → per frame:
  - an=1110 with sseg=CC ×3
  - an=1101 with sseg=86 ×3
  - an=1011 with sseg=92 ×3
  - an=0111 with sseg=CF ×3
  - each slot is preceded by one cycle of 1111/FF.
- Leading zeros: blank_lz=1, hex=0,0,0,5 → only an=1110 (sseg=A4) ever asserted; the other slots stay 1111/FF. hex=0,0,0,0 → digit 0 shows 81. hex=0,1,0,0 → digits 0-2 lit, digit 3 dark.
- Decimal point: dp_in=0100, hex=0,1,2,3 → slot 2 sseg=4F. Same with blank_lz=1 and hex=0,0,0,3 → slot 2 dark (dp suppressed).
- Blink: blink=1 → all-off for the 32 consecutive cycles where bcnt[5]=1; normal scan during the other 32. Drop blink mid-dark phase → scan resumes at the next edge.
- Live update: change hex0 from 4 to 7 mid-slot 0 → sseg becomes 8F at the next edge with no extra dead cycle. No cycle ever shows more than one an bit low.

Source files
------------

// File: rtl/stopwatch_seg_mux.sv
// Scans four hex digits plus decimal points onto a common-anode 7-segment display.
// Latency: 1 clock from inputs/counters to the registered an/sseg outputs.
// Backpressure: none; inputs are sampled live every clock and never stalled.
//
// Ports:
//   clk       system clock (single domain)
//   reset     asynchronous, active-high reset
//   hex3..0   digit codes, hex3 leftmost (minutes tens), hex0 rightmost
//   dp_in     decimal-point requests, bit i lights the dp of digit i
//   blank_lz  1 = blank leading zeros on digits 3..1
//   blink     1 = flash the whole display with the blink counter MSB
//   an        anode enables, active-low, an[i] drives digit i
//   sseg      segments, active-low, {dp, a, b, c, d, e, f, g}
//
// REFRESH_BITS must be >= 3 and BLINK_BITS must be >= 2.

module stopwatch_seg_mux #(
  parameter int REFRESH_BITS = 18,
  parameter int BLINK_BITS   = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hex3,
  input  logic [3:0] hex2,
  input  logic [3:0] hex1,
  input  logic [3:0] hex0,
  input  logic [3:0] dp_in,
  input  logic       blank_lz,
  input  logic       blink,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  localparam logic [REFRESH_BITS-1:0] RCNT_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};
  localparam logic [BLINK_BITS-1:0]   BCNT_ONE = {{(BLINK_BITS-1){1'b0}}, 1'b1};

  logic [REFRESH_BITS-1:0] rcnt_q, rcnt_d;
  logic [BLINK_BITS-1:0]   bcnt_q, bcnt_d;
  logic [3:0]              an_q, an_d;
  logic [7:0]              sseg_q, sseg_d;

  logic [1:0] slot;
  logic       dead_time;
  logic       lz_blank;
  logic       blink_dark;
  logic       blank;
  logic [3:0] hex_sel;
  logic       dp_sel;
  logic [6:0] seg_sel;

  // Hex to active-low abcdefg.
  function automatic logic [6:0] enc(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    rcnt_d = rcnt_q + RCNT_ONE;
    bcnt_d = bcnt_q + BCNT_ONE;

    slot = rcnt_q[REFRESH_BITS-1 -: 2];

    // First cycle of each slot is kept dark so the previous digit's
    // segments never bleed onto the newly enabled anode.
    dead_time = (rcnt_q[REFRESH_BITS-3:0] == '0);

    hex_sel  = hex0;
    dp_sel   = dp_in[0];
    lz_blank = 1'b0;
    case (slot)
      2'd0: begin
        hex_sel  = hex0;
        dp_sel   = dp_in[0];
        lz_blank = 1'b0;
      end
      2'd1: begin
        hex_sel  = hex1;
        dp_sel   = dp_in[1];
        lz_blank = (hex3 == 4'h0) && (hex2 == 4'h0) && (hex1 == 4'h0);
      end
      2'd2: begin
        hex_sel  = hex2;
        dp_sel   = dp_in[2];
        lz_blank = (hex3 == 4'h0) && (hex2 == 4'h0);
      end
      default: begin
        hex_sel  = hex3;
        dp_sel   = dp_in[3];
        lz_blank = (hex3 == 4'h0);
      end
    endcase

    seg_sel    = enc(hex_sel);
    blink_dark = blink & bcnt_q[BLINK_BITS-1];
    blank      = dead_time | (blank_lz & lz_blank) | blink_dark;

    // A blanked digit drops its decimal point too.
    an_d   = 4'b1111;
    sseg_d = 8'hFF;
    if (!blank) begin
      an_d[slot] = 1'b0;
      sseg_d     = {~dp_sel, seg_sel};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt_q <= '0;
      bcnt_q <= '0;
      an_q   <= 4'b1111;
      sseg_q <= 8'hFF;
    end else begin
      rcnt_q <= rcnt_d;
      bcnt_q <= bcnt_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_stopwatch_seg_mux.sv
module tb_stopwatch_seg_mux;

  logic       clk;
  logic       reset;
  logic [3:0] hex3, hex2, hex1, hex0;
  logic [3:0] dp_in;
  logic       blank_lz;
  logic       blink;
  logic [3:0] an;
  logic [7:0] sseg;

  int checks = 0;
  int errors = 0;
  int n = 0;   // edges seen since the last reset release

  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
    string      tag;
  } exp_t;

  exp_t sb[$];

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  stopwatch_seg_mux #(.REFRESH_BITS(4), .BLINK_BITS(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .hex3     (hex3),
    .hex2     (hex2),
    .hex1     (hex1),
    .hex0     (hex0),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .blink    (blink),
    .an       (an),
    .sseg     (sseg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: what the display should show at the edge that sees
  // refresh position r (0..15) and blink position b (0..63).
  function automatic logic [11:0] model(input int r, input int b);
    int         s;
    logic [3:0] h [4];
    logic       lz;
    logic [3:0] a;
    s    = r / 4;
    h[0] = hex0; h[1] = hex1; h[2] = hex2; h[3] = hex3;
    case (s)
      3:       lz = (hex3 == 0);
      2:       lz = (hex3 == 0) && (hex2 == 0);
      1:       lz = (hex3 == 0) && (hex2 == 0) && (hex1 == 0);
      default: lz = 1'b0;
    endcase
    if ((r % 4) == 0 || (blank_lz && lz) || (blink && b >= 32))
      return {4'b1111, 8'hFF};
    a    = 4'b1111;
    a[s] = 1'b0;
    return {a, ~dp_in[s], seg_tab[h[s]]};
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    n++;
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: no expectation queued at edge %0d", n);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (an === e.an) else begin
        errors++;
        $error("FAIL %s an: got %b expected %b (edge %0d)", e.tag, an, e.an, n);
      end
      checks++;
      assert (sseg === e.sseg) else begin
        errors++;
        $error("FAIL %s sseg: got %h expected %h (edge %0d)", e.tag, sseg, e.sseg, n);
      end
    end
    checks++;
    assert ($countones(~an) <= 1) else begin
      errors++;
      $error("FAIL onehot an: got %b expected at most one low bit", an);
    end
  endtask

  task automatic step(input string tag);
    logic [11:0] v;
    v = model(n % 16, n % 64);
    sb.push_back('{an: v[11:8], sseg: v[7:0], tag: tag});
    tick();
  endtask

  task automatic lit(input logic [3:0] a, input logic [7:0] s, input string tag);
    sb.push_back('{an: a, sseg: s, tag: tag});
    tick();
  endtask

  task automatic steps(input int k, input string tag);
    for (int i = 0; i < k; i++) step(tag);
  endtask

  task automatic align(input int t);
    for (int i = 0; i < 16 && (n % 16) != t; i++) step("align");
  endtask

  task automatic set_hex(input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0);
    hex3 = d3; hex2 = d2; hex1 = d1; hex0 = d0;
  endtask

  initial begin
    logic [7:0] scan_seg [4];
    logic [3:0] a;
    scan_seg[0] = 8'hCC; scan_seg[1] = 8'h86; scan_seg[2] = 8'h92; scan_seg[3] = 8'hCF;

    reset = 1'b1;
    set_hex(4'd1, 4'd2, 4'd3, 4'd4);
    dp_in    = 4'b0000;
    blank_lz = 1'b0;
    blink    = 1'b0;

    #12;
    checks++;
    assert (an === 4'b1111) else begin
      errors++;
      $error("FAIL reset_an: got %b expected 1111", an);
    end
    checks++;
    assert (sseg === 8'hFF) else begin
      errors++;
      $error("FAIL reset_sseg: got %h expected ff", sseg);
    end
    reset = 1'b0;
    n = 0;

    // First frame after release, written out literally.
    for (int s = 0; s < 4; s++) begin
      a = 4'b1111;
      a[s] = 1'b0;
      lit(4'b1111, 8'hFF, "scan_dead");
      for (int k = 0; k < 3; k++) lit(a, scan_seg[s], "scan");
    end
    steps(16, "scan_model");

    // Live update mid-slot 0.
    align(1);
    lit(4'b1110, 8'hCC, "live_pre");
    hex0 = 4'd7;
    lit(4'b1110, 8'h8F, "live_post");
    steps(14, "live_model");

    // Leading-zero blanking.
    blank_lz = 1'b1;
    set_hex(4'd0, 4'd0, 4'd0, 4'd5);
    steps(32, "lz_0005");
    align(1);
    lit(4'b1110, 8'hA4, "lz_0005_d0");
    set_hex(4'd0, 4'd0, 4'd0, 4'd0);
    align(1);
    lit(4'b1110, 8'h81, "lz_0000_d0");
    steps(16, "lz_0000");
    set_hex(4'd0, 4'd1, 4'd0, 4'd0);
    steps(16, "lz_0100");
    align(13);
    lit(4'b1111, 8'hFF, "lz_0100_d3");
    align(9);
    lit(4'b1011, 8'hCF, "lz_0100_d2");

    // Decimal points.
    blank_lz = 1'b0;
    dp_in = 4'b0100;
    set_hex(4'd0, 4'd1, 4'd2, 4'd3);
    align(9);
    lit(4'b1011, 8'h4F, "dp_lit");
    steps(16, "dp_model");
    blank_lz = 1'b1;
    set_hex(4'd0, 4'd0, 4'd0, 4'd3);
    align(9);
    lit(4'b1111, 8'hFF, "dp_suppressed");
    steps(16, "dp_lz_model");

    // Blink.
    blank_lz = 1'b0;
    dp_in = 4'b0000;
    set_hex(4'd1, 4'd2, 4'd3, 4'd4);
    blink = 1'b1;
    for (int i = 0; i < 64 && (n % 64) != 32; i++) step("blink_pre");
    for (int i = 0; i < 9; i++) lit(4'b1111, 8'hFF, "blink_dark");
    blink = 1'b0;
    lit(4'b1011, 8'h92, "blink_drop");
    blink = 1'b1;
    steps(70, "blink_model");
    blink = 1'b0;
    steps(5, "post_blink");

    // Asynchronous reset between edges, held across one edge.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    assert (an === 4'b1111) else begin
      errors++;
      $error("FAIL async_rst_an: got %b expected 1111", an);
    end
    checks++;
    assert (sseg === 8'hFF) else begin
      errors++;
      $error("FAIL async_rst_sseg: got %h expected ff", sseg);
    end
    #10;
    checks++;
    assert (an === 4'b1111 && sseg === 8'hFF) else begin
      errors++;
      $error("FAIL rst_held: got %b/%h expected 1111/ff", an, sseg);
    end
    reset = 1'b0;
    n = 0;
    lit(4'b1111, 8'hFF, "rel_edge1");
    for (int k = 0; k < 3; k++) lit(4'b1110, 8'hCC, "rel_slot0");
    lit(4'b1111, 8'hFF, "rel_dead1");
    lit(4'b1101, 8'h86, "rel_slot1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
